// File: rtl/dm_byte_lane.sv
// dm_byte_lane: 1024 x 32-bit little-endian data memory with byte-lane stores,
// sign/zero-extending loads and alignment/range checking.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   reset    - synchronous active-high reset; clears array, fault and wr_cnt
//   we       - store request this cycle
//   st_op    - store width: 0 sw, 1 sh, 2 sb, 3 reserved
//   ld_op    - load format: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5-7 reserved
//   addr     - byte address shared by load and store
//   wd       - right-justified store data
//   rd       - extended load data (combinational)
//   misalign - current store (if requested) or load is rejected (combinational)
//   fault    - sticky flag, set by any rejected store
//   wr_cnt   - count of committed stores, wraps at 16 bits
module dm_byte_lane (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  st_op,
   input  logic [2:0]  ld_op,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        misalign,
   output logic        fault,
   output logic [15:0] wr_cnt
);

   localparam logic [1:0] StSw  = 2'd0;
   localparam logic [1:0] StSh  = 2'd1;
   localparam logic [1:0] StSb  = 2'd2;

   localparam logic [2:0] LdLw  = 3'd0;
   localparam logic [2:0] LdLh  = 3'd1;
   localparam logic [2:0] LdLhu = 3'd2;
   localparam logic [2:0] LdLb  = 3'd3;
   localparam logic [2:0] LdLbu = 3'd4;

   // Packed so the whole array clears with a single assignment in reset.
   logic [1023:0][31:0] mem_q;
   logic                fault_q;
   logic [15:0]         wr_cnt_q;

   logic [9:0]  widx;
   logic        in_range;
   logic [31:0] word;

   logic        st_aligned;
   logic [3:0]  st_be;
   logic [31:0] st_data;
   logic        st_bad;
   logic        st_commit;
   logic        st_reject;

   logic        ld_ok;
   logic [15:0] ld_half;
   logic [7:0]  ld_byte;
   logic [31:0] ld_data;

   assign widx     = addr[11:2];
   assign in_range = (addr[31:12] == 20'h0);
   assign word     = mem_q[widx];

   // Store decode: lane enables plus data replicated across lanes.
   always_comb begin
      st_aligned = 1'b0;
      st_be      = 4'b0000;
      st_data    = wd;
      unique case (st_op)
         StSw: begin
            st_aligned = (addr[1:0] == 2'b00);
            st_be      = 4'b1111;
         end
         StSh: begin
            st_aligned = ~addr[0];
            st_be      = addr[1] ? 4'b1100 : 4'b0011;
            st_data    = {2{wd[15:0]}};
         end
         StSb: begin
            st_aligned = 1'b1;
            st_be      = 4'b0001 << addr[1:0];
            st_data    = {4{wd[7:0]}};
         end
         default: begin
            // Reserved width is treated as never aligned.
            st_aligned = 1'b0;
            st_be      = 4'b0000;
         end
      endcase
   end

   assign st_bad    = ~in_range | ~st_aligned;
   assign st_commit = we & ~st_bad;
   assign st_reject = we & st_bad;

   // Load path: select half/byte from the addressed word, then extend.
   always_comb begin
      ld_half = addr[1] ? word[31:16] : word[15:0];
      unique case (addr[1:0])
         2'd0:    ld_byte = word[7:0];
         2'd1:    ld_byte = word[15:8];
         2'd2:    ld_byte = word[23:16];
         default: ld_byte = word[31:24];
      endcase

      ld_ok   = 1'b0;
      ld_data = 32'h0;
      unique case (ld_op)
         LdLw: begin
            ld_ok   = (addr[1:0] == 2'b00);
            ld_data = word;
         end
         LdLh: begin
            ld_ok   = ~addr[0];
            ld_data = {{16{ld_half[15]}}, ld_half};
         end
         LdLhu: begin
            ld_ok   = ~addr[0];
            ld_data = {16'h0, ld_half};
         end
         LdLb: begin
            ld_ok   = 1'b1;
            ld_data = {{24{ld_byte[7]}}, ld_byte};
         end
         LdLbu: begin
            ld_ok   = 1'b1;
            ld_data = {24'h0, ld_byte};
         end
         default: begin
            ld_ok   = 1'b0;
            ld_data = 32'h0;
         end
      endcase
      ld_ok = ld_ok & in_range;
   end

   assign rd       = ld_ok ? ld_data : 32'h0;
   // Reset does not mask this; it only reports the current access.
   assign misalign = st_reject | ~ld_ok;
   assign fault    = fault_q;
   assign wr_cnt   = wr_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '0;
         fault_q  <= 1'b0;
         wr_cnt_q <= 16'h0;
      end else begin
         if (st_commit) begin
            for (int b = 0; b < 4; b++) begin
               if (st_be[b]) begin
                  mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
               end
            end
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
         if (st_reject) begin
            fault_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dm_byte_lane.sv
// Self-checking bench for dm_byte_lane: directed scenarios, randomized traffic
// against a byte-addressed reference model, and a write-counter wrap run.
module tb_dm_byte_lane;

   logic        clk;
   logic        reset;
   logic        we;
   logic [1:0]  st_op;
   logic [2:0]  ld_op;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        misalign;
   logic        fault;
   logic [15:0] wr_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: plain byte array, stores write N consecutive bytes.
   logic [7:0]  mb [4096];
   logic        m_fault;
   logic [15:0] m_cnt;

   dm_byte_lane dut (
      .clk      (clk),
      .reset    (reset),
      .we       (we),
      .st_op    (st_op),
      .ld_op    (ld_op),
      .addr     (addr),
      .wd       (wd),
      .rd       (rd),
      .misalign (misalign),
      .fault    (fault),
      .wr_cnt   (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic int st_len(input logic [1:0] op);
      return (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : (op == 2'd2) ? 1 : 0;
   endfunction

   function automatic int ld_len(input logic [2:0] op);
      return (op == 3'd0) ? 4 : (op == 3'd1 || op == 3'd2) ? 2 :
             (op == 3'd3 || op == 3'd4) ? 1 : 0;
   endfunction

   // Access is valid when in range, width is defined, and address is a multiple of width.
   function automatic bit m_st_ok(input logic [1:0] op, input logic [31:0] a);
      int n = st_len(op);
      return (a[31:12] == 0) && (n != 0) && ((a % n) == 0);
   endfunction

   function automatic bit m_ld_ok(input logic [2:0] op, input logic [31:0] a);
      int n = ld_len(op);
      return (a[31:12] == 0) && (n != 0) && ((a % n) == 0);
   endfunction

   function automatic logic [31:0] m_rd(input logic [2:0] op, input logic [31:0] a);
      int i;
      logic [31:0] v;
      if (!m_ld_ok(op, a)) return 32'h0;
      i = int'(a[11:0]);
      v = 32'h0;
      for (int k = 0; k < ld_len(op); k++) v = v | (32'(mb[i+k]) << (8 * k));
      if (op == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      if (op == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
      return v;
   endfunction

   function automatic bit m_misalign(input logic w, input logic [1:0] so, input logic [2:0] lo,
                                     input logic [31:0] a);
      return (w && !m_st_ok(so, a)) || !m_ld_ok(lo, a);
   endfunction

   // Apply the currently driven inputs to the model, as the edge would.
   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 4096; i++) mb[i] = 8'h0;
         m_fault = 1'b0;
         m_cnt   = 16'h0;
      end else if (we) begin
         if (m_st_ok(st_op, addr)) begin
            for (int k = 0; k < st_len(st_op); k++) mb[int'(addr[11:0]) + k] = wd[8*k +: 8];
            m_cnt = m_cnt + 16'd1;
         end else begin
            m_fault = 1'b1;
         end
      end
   endtask

   // One full cycle: drive at negedge, check combinational outputs, clock, check state.
   task automatic cyc(input logic r, input logic w, input logic [1:0] so, input logic [2:0] lo,
                      input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      reset = r; we = w; st_op = so; ld_op = lo; addr = a; wd = d;
      #1;
      check("rd_pre", rd, m_rd(lo, a));
      check("misalign", 32'(misalign), 32'(m_misalign(w, so, lo, a)));
      @(posedge clk);
      model_edge();
      #1;
      check("fault", 32'(fault), 32'(m_fault));
      check("wr_cnt", 32'(wr_cnt), 32'(m_cnt));
   endtask

   // Idle-cycle load probe against a fixed expected value.
   task automatic peek(input string tag, input logic [2:0] lo, input logic [31:0] a,
                       input logic [31:0] exp);
      @(negedge clk);
      reset = 1'b0; we = 1'b0; st_op = 2'd0; ld_op = lo; addr = a; wd = 32'h0;
      #1;
      check(tag, rd, exp);
   endtask

   initial begin
      logic [31:0] ra;
      reset = 1'b1; we = 1'b0; st_op = 2'd0; ld_op = 3'd0; addr = 32'h0; wd = 32'h0;
      @(posedge clk);
      model_edge();
      #1;
      check("reset_fault", 32'(fault), 32'h0);
      check("reset_cnt", 32'(wr_cnt), 32'h0);
      peek("reset_lw0", 3'd0, 32'h0, 32'h0);

      // sw / lbu / lh
      cyc(1'b0, 1'b1, 2'd0, 3'd0, 32'h10, 32'h1234_5678);
      peek("lw_10", 3'd0, 32'h10, 32'h1234_5678);
      peek("lbu_13", 3'd4, 32'h13, 32'h0000_0012);
      peek("lh_12", 3'd1, 32'h12, 32'h0000_1234);
      check("cnt_1", 32'(wr_cnt), 32'h1);

      // sb onto a cleared word
      cyc(1'b1, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 2'd2, 3'd0, 32'h11, 32'hFFFF_FF80);
      peek("sb_lw_10", 3'd0, 32'h10, 32'h0000_8000);
      peek("lb_11", 3'd3, 32'h11, 32'hFFFF_FF80);
      peek("lbu_11", 3'd4, 32'h11, 32'h0000_0080);

      // sh into upper half
      cyc(1'b0, 1'b1, 2'd0, 3'd0, 32'h20, 32'h1111_2222);
      cyc(1'b0, 1'b1, 2'd1, 3'd0, 32'h22, 32'h0000_ABCD);
      peek("sh_lw_20", 3'd0, 32'h20, 32'hABCD_2222);
      peek("lh_22", 3'd1, 32'h22, 32'hFFFF_ABCD);

      // Rejected stores
      cyc(1'b0, 1'b1, 2'd0, 3'd0, 32'h21, 32'hFFFF_FFFF);
      check("fault_after_rej", 32'(fault), 32'h1);
      cyc(1'b0, 1'b1, 2'd1, 3'd0, 32'h23, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b1, 2'd0, 3'd0, 32'h1000, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b1, 2'd3, 3'd4, 32'h20, 32'hFFFF_FFFF);
      peek("rej_lw_20", 3'd0, 32'h20, 32'hABCD_2222);
      check("rej_cnt", 32'(wr_cnt), 32'h3);

      // Reset beats a simultaneous store
      cyc(1'b1, 1'b1, 2'd0, 3'd0, 32'h40, 32'hDEAD_BEEF);
      peek("rst_lw_40", 3'd0, 32'h40, 32'h0);
      check("rst_fault", 32'(fault), 32'h0);
      check("rst_cnt", 32'(wr_cnt), 32'h0);
      cyc(1'b0, 1'b1, 2'd0, 3'd0, 32'h40, 32'hCAFE_F00D);
      peek("resume_lw_40", 3'd0, 32'h40, 32'hCAFE_F00D);

      // Randomized traffic over a small window so words get revisited
      for (int n = 0; n < 3000; n++) begin
         ra = {($urandom_range(0, 15) == 0) ? 20'h1 : 20'h0,
               10'($urandom_range(0, 15)), 2'($urandom)};
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
             2'($urandom), 3'($urandom_range(0, 7)), ra, $urandom);
      end

      // Counter wrap
      cyc(1'b1, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b0; we = 1'b1; st_op = 2'd2; ld_op = 3'd4; addr = 32'h5; wd = 32'h0000_00A5;
      for (int n = 0; n < 65535; n++) begin
         @(posedge clk);
         model_edge();
      end
      #1;
      check("cnt_ffff", 32'(wr_cnt), 32'h0000_FFFF);
      @(posedge clk);
      model_edge();
      #1;
      check("cnt_wrap", 32'(wr_cnt), 32'h0);
      check("cnt_wrap_model", 32'(wr_cnt), 32'(m_cnt));
      peek("wrap_lbu_5", 3'd4, 32'h5, 32'h0000_00A5);
      check("wrap_fault", 32'(fault), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
